// File: rtl/sqdet_pkg.sv
// Shared constants and helpers for the sequence-detector event logger.
package sqdet_pkg;
  localparam int TS_W_DEF  = 16;
  localparam int CNT_W_DEF = 16;
  localparam int DEPTH_DEF = 4;

  // Counter widths up to 32 bits; the caller passes its all-ones ceiling.
  function automatic logic [31:0] sat_inc(input logic [31:0] v, input logic [31:0] maxv);
    return (v >= maxv) ? v : v + 32'd1;
  endfunction
endpackage

// File: rtl/ev_fifo.sv
// Synchronous FIFO; a push into a full FIFO is taken only alongside a pop.
module ev_fifo #(
  parameter int W     = 16,
  parameter int DEPTH = 4
) (
  input  logic         clk,
  input  logic         clr,
  input  logic         push,
  input  logic         pop,
  input  logic [W-1:0] din,
  output logic [W-1:0] dout,
  output logic         full,
  output logic         empty
);
  localparam int AW = $clog2(DEPTH);

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wp, rp;
  logic [AW:0]   cnt;
  logic          push_ok, pop_ok;

  assign full    = (cnt == (AW+1)'(DEPTH));
  assign empty   = (cnt == '0);
  assign pop_ok  = pop && !empty;
  assign push_ok = push && (!full || pop_ok);
  assign dout    = mem[rp];

  // Storage is cleared too so the head word reads 0 out of reset.
  always_ff @(posedge clk) begin
    if (clr) begin
      wp  <= '0;
      rp  <= '0;
      cnt <= '0;
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else begin
      if (push_ok) begin
        mem[wp] <= din;
        wp      <= wp + 1'b1;
      end
      if (pop_ok) rp <= rp + 1'b1;
      case ({push_ok, pop_ok})
        2'b10:   cnt <= cnt + 1'b1;
        2'b01:   cnt <= cnt - 1'b1;
        default: cnt <= cnt;
      endcase
    end
  end
endmodule

// File: rtl/sqdet_event_log.sv
// Timestamps detector strobes into a FIFO and keeps saturating accept/drop counts.
module sqdet_event_log
  import sqdet_pkg::*;
#(
  parameter int TS_W  = TS_W_DEF,
  parameter int DEPTH = DEPTH_DEF,
  parameter int CNT_W = CNT_W_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             det_in,
  input  logic             en,
  input  logic             clr,
  output logic             ev_valid,
  input  logic             ev_ready,
  output logic [TS_W-1:0]  ev_ts,
  output logic [CNT_W-1:0] det_count,
  output logic [CNT_W-1:0] drop_count,
  output logic             ovf
);
  localparam logic [31:0] CNT_MAX = 32'((64'd1 << CNT_W) - 64'd1);

  logic [TS_W-1:0] ts;
  logic            wipe, det, pop, push, drop, full, empty;

  assign wipe     = rst || clr;
  assign det      = en && det_in;
  assign ev_valid = !empty;
  assign pop      = ev_valid && ev_ready;
  // A full FIFO still takes a detection when the head leaves on the same edge.
  assign push     = det && (!full || pop);
  assign drop     = det && full && !pop;

  ev_fifo #(.W(TS_W), .DEPTH(DEPTH)) u_fifo (
    .clk   (clk),
    .clr   (wipe),
    .push  (push),
    .pop   (pop),
    .din   (ts),
    .dout  (ev_ts),
    .full  (full),
    .empty (empty)
  );

  always_ff @(posedge clk) begin
    if (wipe) begin
      ts         <= '0;
      det_count  <= '0;
      drop_count <= '0;
      ovf        <= 1'b0;
    end else begin
      ts <= ts + 1'b1;
      if (push) det_count <= CNT_W'(sat_inc(32'(det_count), CNT_MAX));
      if (drop) begin
        drop_count <= CNT_W'(sat_inc(32'(drop_count), CNT_MAX));
        ovf        <= 1'b1;
      end
    end
  end
endmodule
